// File: rtl/shift_add_mul_pkg.sv
// Shared types and defaults for the shift-and-add multiplier.
// The multiplier and its adder both import this package.
package mul_pkg;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } mul_state_t;

    localparam int MUL_WIDTH_DEFAULT = 6;

endpackage

// File: rtl/shift_add_mul_rca.sv
// Ripple-carry adder: WIDTH-bit operands plus carry-in, WIDTH+1-bit sum.
// The top bit of the sum is the final carry out.
module rca_adder
    import mul_pkg::*;
#(
    parameter int WIDTH = MUL_WIDTH_DEFAULT
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             c_in,
    output logic [WIDTH:0]   sum
);

    logic [WIDTH:0] carry;

    assign carry[0] = c_in;

    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        assign sum[i]     = a[i] ^ b[i] ^ carry[i];
        assign carry[i+1] = (a[i] & b[i]) | (carry[i] & (a[i] ^ b[i]));
    end

    assign sum[WIDTH] = carry[WIDTH];

endmodule

// File: rtl/shift_add_mul.sv
// Iterative unsigned multiplier: one shift-and-add step per cycle,
// valid/ready handshakes on the operand side and the result side.
module shift_add_mul
    import mul_pkg::*;
#(
    parameter int WIDTH = MUL_WIDTH_DEFAULT
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [WIDTH-1:0]     a_i,
    input  logic [WIDTH-1:0]     b_i,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [2*WIDTH-1:0]   product_o,
    output logic                 busy_o
);

    localparam int CNT_W = $clog2(WIDTH + 1);

    mul_state_t state;
    mul_state_t next_state;

    logic [WIDTH-1:0]   mcand;
    // The carry bit P[2W] is always zero once the step's shift is applied,
    // so only the low 2W bits are stored; the carry lives in the adder sum.
    logic [2*WIDTH-1:0] p;
    logic [CNT_W-1:0]   cnt;

    logic [WIDTH-1:0]   add_b;
    logic [WIDTH:0]     sum;
    logic [2*WIDTH-1:0] p_next;
    logic               accept;
    logic               last_step;

    assign accept    = in_valid && (state == IDLE);
    assign last_step = (state == RUN) && (cnt == CNT_W'(WIDTH - 1));
    assign add_b     = p[0] ? mcand : '0;
    assign p_next    = {sum, p[WIDTH-1:1]};

    rca_adder #(
        .WIDTH (WIDTH)
    ) u_adder (
        .a    (p[2*WIDTH-1:WIDTH]),
        .b    (add_b),
        .c_in (1'b0),
        .sum  (sum)
    );

    // NOTE: state registers use non-blocking assignments so every flop
    // samples the pre-edge values regardless of process ordering.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // NOTE: next_state gets a default before the case so no path leaves it
    // unassigned, which would otherwise infer a latch.
    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (in_valid)  next_state = RUN;
            RUN:     if (last_step) next_state = DONE;
            DONE:    if (out_ready) next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mcand     <= '0;
            p         <= '0;
            cnt       <= '0;
            product_o <= '0;
        end else if (accept) begin
            mcand <= a_i;
            p     <= {{WIDTH{1'b0}}, b_i};
            cnt   <= '0;
        end else if (state == RUN) begin
            p   <= p_next;
            cnt <= cnt + 1'b1;
            if (last_step) begin
                product_o <= p_next;
            end
        end
    end

    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);
    assign busy_o    = (state != IDLE);

endmodule

// File: tb/tb_shift_add_mul.sv
// Directed and exhaustive checks for shift_add_mul at WIDTH=6.
// Inputs are driven and outputs sampled 1ns after each rising edge.
module tb_shift_add_mul;

    localparam int WIDTH = 6;

    logic                 clk;
    logic                 rst;
    logic                 in_valid;
    logic                 in_ready;
    logic [WIDTH-1:0]     a_i;
    logic [WIDTH-1:0]     b_i;
    logic                 out_valid;
    logic                 out_ready;
    logic [2*WIDTH-1:0]   product_o;
    logic                 busy_o;

    int errors = 0;
    int checks = 0;

    shift_add_mul #(
        .WIDTH (WIDTH)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a_i       (a_i),
        .b_i       (b_i),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .product_o (product_o),
        .busy_o    (busy_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Presents one operand pair for a single edge; caller ensures in_ready=1.
    task automatic accept(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
        in_valid = 1'b1;
        a_i      = a;
        b_i      = b;
        step();
        in_valid = 1'b0;
    endtask

    // Steps until out_valid is seen or the budget runs out.
    task automatic wait_out(input int budget, output int n, output bit ok);
        n = 0;
        while (!out_valid && n < budget) begin
            step();
            n++;
        end
        ok = out_valid;
    endtask

    task automatic test_reset();
        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        a_i       = '0;
        b_i       = '0;
        step();
        step();
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || busy_o !== 1'b0 ||
            product_o !== 12'd0) begin
            errors++;
            $display("FAIL reset_state: in_ready=%b out_valid=%b busy=%b product=%0d, required 1 0 0 0",
                     in_ready, out_valid, busy_o, product_o);
        end
        rst = 1'b0;
        step();
    endtask

    task automatic test_zero();
        int lows;
        int valid_at;
        out_ready = 1'b1;
        accept(6'd0, 6'd0);
        lows     = 0;
        valid_at = -1;
        for (int i = 0; i < 12; i++) begin
            if (!in_ready) lows++;
            if (out_valid && valid_at < 0) begin
                valid_at = i;
                checks++;
                if (product_o !== 12'd0) begin
                    errors++;
                    $display("FAIL zero_product: got %0d, required 0", product_o);
                end
            end
            step();
        end
        checks++;
        if (lows !== 7) begin
            errors++;
            $display("FAIL zero_in_ready_low: got %0d cycles, required 7", lows);
        end
        checks++;
        if (valid_at !== 6) begin
            errors++;
            $display("FAIL zero_latency: out_valid after edge t0+%0d, required t0+6", valid_at);
        end
    endtask

    task automatic test_max();
        int  n;
        bit  ok;
        out_ready = 1'b1;
        accept(6'd63, 6'd63);
        wait_out(20, n, ok);
        checks++;
        if (!ok || n !== 6 || product_o !== 12'd3969) begin
            errors++;
            $display("FAIL max_product: ok=%b after=%0d product=%0d, required ok after 6 with 3969",
                     ok, n, product_o);
        end
        step();
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL max_single_valid: out_valid=%b in_ready=%b, required 0 1",
                     out_valid, in_ready);
        end
    endtask

    task automatic test_backpressure();
        int  n;
        bit  ok;
        out_ready = 1'b0;
        accept(6'd5, 6'd7);
        wait_out(20, n, ok);
        checks++;
        if (!ok || product_o !== 12'd35) begin
            errors++;
            $display("FAIL bp_product: ok=%b product=%0d, required ok with 35", ok, product_o);
        end
        in_valid = 1'b1;
        a_i      = 6'd9;
        b_i      = 6'd9;
        for (int i = 0; i < 4; i++) begin
            step();
            checks++;
            if (out_valid !== 1'b1 || product_o !== 12'd35 || in_ready !== 1'b0) begin
                errors++;
                $display("FAIL bp_hold_%0d: out_valid=%b product=%0d in_ready=%b, required 1 35 0",
                         i, out_valid, product_o, in_ready);
            end
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        step();
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 || product_o !== 12'd35) begin
            errors++;
            $display("FAIL bp_release: out_valid=%b in_ready=%b product=%0d, required 0 1 35",
                     out_valid, in_ready, product_o);
        end
    endtask

    task automatic test_abort();
        int  n;
        bit  ok;
        out_ready = 1'b1;
        accept(6'd32, 6'd2);
        step();
        step();
        step();
        rst = 1'b1;
        #1;
        checks++;
        if (out_valid !== 1'b0 || product_o !== 12'd0 || in_ready !== 1'b1 || busy_o !== 1'b0) begin
            errors++;
            $display("FAIL abort_async: out_valid=%b product=%0d in_ready=%b busy=%b, required 0 0 1 0",
                     out_valid, product_o, in_ready, busy_o);
        end
        rst = 1'b0;
        step();
        accept(6'd1, 6'd63);
        wait_out(20, n, ok);
        checks++;
        if (!ok || n !== 6 || product_o !== 12'd63) begin
            errors++;
            $display("FAIL abort_recover: ok=%b after=%0d product=%0d, required ok after 6 with 63",
                     ok, n, product_o);
        end
        step();
    endtask

    task automatic test_back_to_back();
        int  n;
        bit  ok;
        out_ready = 1'b1;
        in_valid  = 1'b1;
        a_i       = 6'd12;
        b_i       = 6'd11;
        step();
        a_i = 6'd21;
        b_i = 6'd3;
        wait_out(20, n, ok);
        checks++;
        if (!ok || n !== 6 || product_o !== 12'd132) begin
            errors++;
            $display("FAIL b2b_first: ok=%b after=%0d product=%0d, required ok after 6 with 132",
                     ok, n, product_o);
        end
        step();
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL b2b_idle_gap: in_ready=%b out_valid=%b, required 1 0", in_ready, out_valid);
        end
        step();
        in_valid = 1'b0;
        checks++;
        if (in_ready !== 1'b0 || busy_o !== 1'b1) begin
            errors++;
            $display("FAIL b2b_second_accept: in_ready=%b busy=%b, required 0 1", in_ready, busy_o);
        end
        wait_out(20, n, ok);
        checks++;
        if (!ok || n !== 6 || product_o !== 12'd63) begin
            errors++;
            $display("FAIL b2b_second: ok=%b after=%0d product=%0d, required ok after 6 with 63",
                     ok, n, product_o);
        end
        step();
    endtask

    task automatic test_sweep();
        int              guard;
        bit              done;
        logic [2*WIDTH-1:0] expected;
        for (int a = 0; a < 64; a++) begin
            for (int b = 0; b < 64; b++) begin
                guard = 0;
                while (!in_ready && guard < 40) begin
                    out_ready = 1'b1;
                    step();
                    guard++;
                end
                accept(6'(a), 6'(b));
                expected = 12'(a * b);
                done     = 1'b0;
                guard    = 0;
                while (!done && guard < 40) begin
                    out_ready = 1'($urandom_range(0, 1));
                    if (out_valid && out_ready) begin
                        done = 1'b1;
                        checks++;
                        if (product_o !== expected) begin
                            errors++;
                            if (errors < 20)
                                $display("FAIL sweep_%0d_%0d: got %0d, required %0d",
                                         a, b, product_o, expected);
                        end
                    end
                    step();
                    guard++;
                end
                if (!done) begin
                    checks++;
                    errors++;
                    if (errors < 20)
                        $display("FAIL sweep_timeout_%0d_%0d: no handshake within 40 cycles, required one", a, b);
                end
            end
        end
        out_ready = 1'b0;
    endtask

    initial begin
        test_reset();
        test_zero();
        test_max();
        test_backpressure();
        test_abort();
        test_back_to_back();
        test_sweep();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
